meta_buffer: RTL and testbench

META_BUFFER -- requirements
Module: meta_buffer

---
 rtl/meta_buffer_if.sv | 41 ++++
 rtl/meta_buffer.sv | 119 +++++++++++
 tb/tb_meta_buffer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/meta_buffer_if.sv
// rtl/meta_buffer_if.sv - enqueue/dequeue bundle for the meta buffer
//
// Purpose: groups the enqueue and dequeue handshakes and the fill-level status
// of meta_buffer so a producer/consumer environment can carry them as one
// object.
//
// Ports (signals):
//   enq_valid, enq_ready, enq_glb, enq_seglv  - enqueue handshake and payload
//   deq_valid, deq_ready, deq_glb, deq_seglv  - dequeue handshake and payload
//   usage, empty                              - fill level status
// Modports:
//   master - the side that drives enqueue data and dequeue ready
//   slave  - the buffer side
interface meta_buffer_if #(
  parameter type         meta_glb_t   = logic,
  parameter type         meta_seglv_t = logic,
  parameter int unsigned Depth        = 4
);
  localparam int unsigned CntW = $clog2(Depth) + 1;

  logic            enq_valid;
  logic            enq_ready;
  meta_glb_t       enq_glb;
  meta_seglv_t     enq_seglv;
  logic            deq_valid;
  logic            deq_ready;
  meta_glb_t       deq_glb;
  meta_seglv_t     deq_seglv;
  logic [CntW-1:0] usage;
  logic            empty;

  modport master (
    output enq_valid, enq_glb, enq_seglv, deq_ready,
    input  enq_ready, deq_valid, deq_glb, deq_seglv, usage, empty
  );

  modport slave (
    input  enq_valid, enq_glb, enq_seglv, deq_ready,
    output enq_ready, deq_valid, deq_glb, deq_seglv, usage, empty
  );
endinterface

// File: rtl/meta_buffer.sv
// rtl/meta_buffer.sv - circular FIFO of global/segment-level meta entries
//
// Purpose: buffers meta entries between the control machine (enqueue side)
// and the data controller (dequeue side) in strict FIFO order.
//
// Parameters:
//   Depth        - number of entries, power of two, at least 2
//   meta_glb_t   - global meta payload type
//   meta_seglv_t - segment-level meta payload type
//
// Ports:
//   clk_i        - clock, rising edge
//   rst_ni       - asynchronous active-low reset
//   enq_valid_i  - entry offered
//   enq_ready_o  - buffer not full (registered state only)
//   enq_glb_i    - global meta to enqueue
//   enq_seglv_i  - segment-level meta to enqueue
//   deq_valid_o  - head entry available
//   deq_ready_i  - head entry consumed
//   deq_glb_o    - head global meta
//   deq_seglv_o  - head segment-level meta
//   usage_o      - number of stored entries
//   empty_o      - usage_o == 0
//
// Build option: META_BUF_FALL_THROUGH_EN - when defined, an empty buffer
// presents the enqueue side directly on the dequeue side in the same cycle.
module meta_buffer #(
  parameter int unsigned Depth        = 4,
  parameter type         meta_glb_t   = logic,
  parameter type         meta_seglv_t = logic
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       enq_valid_i,
  output logic                       enq_ready_o,
  input  meta_glb_t                  enq_glb_i,
  input  meta_seglv_t                enq_seglv_i,
  output logic                       deq_valid_o,
  input  logic                       deq_ready_i,
  output meta_glb_t                  deq_glb_o,
  output meta_seglv_t                deq_seglv_o,
  output logic [$clog2(Depth):0]     usage_o,
  output logic                       empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  meta_glb_t       glb_mem   [Depth];
  meta_seglv_t     seglv_mem [Depth];

  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] usage_q;

  logic            is_full;
  logic            is_empty;
  logic            bypass;
  logic            push;
  logic            pop;

  assign is_full     = (usage_q == CntW'(Depth));
  assign is_empty    = (usage_q == '0);

  // Ready comes from stored state only, so a pop in the same cycle never
  // frees a slot for a simultaneous push into a full buffer.
  assign enq_ready_o = !is_full;

`ifdef META_BUF_FALL_THROUGH_EN
  assign deq_valid_o = is_empty ? enq_valid_i : 1'b1;
  assign deq_glb_o   = is_empty ? enq_glb_i   : glb_mem[rd_ptr_q];
  assign deq_seglv_o = is_empty ? enq_seglv_i : seglv_mem[rd_ptr_q];
  // Entry consumed straight off the enqueue side: storage, pointers and
  // usage are left untouched.
  assign bypass      = is_empty && enq_valid_i && deq_ready_i;
`else
  assign deq_valid_o = !is_empty;
  assign deq_glb_o   = glb_mem[rd_ptr_q];
  assign deq_seglv_o = seglv_mem[rd_ptr_q];
  assign bypass      = 1'b0;
`endif

  assign push = enq_valid_i && enq_ready_o && !bypass;
  assign pop  = deq_valid_o && deq_ready_i && !bypass;

  // Storage is intentionally not reset; the head is only meaningful while
  // deq_valid_o is high.
  always_ff @(posedge clk_i) begin
    if (push) begin
      glb_mem[wr_ptr_q]   <= enq_glb_i;
      seglv_mem[wr_ptr_q] <= enq_seglv_i;
    end
  end

  // Depth is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usage_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      case ({push, pop})
        2'b10:   usage_q <= usage_q + CntW'(1);
        2'b01:   usage_q <= usage_q - CntW'(1);
        default: usage_q <= usage_q;
      endcase
    end
  end

  assign usage_o = usage_q;
  assign empty_o = is_empty;

endmodule

// File: tb/tb_meta_buffer.sv
// tb/tb_meta_buffer.sv - self-checking bench for meta_buffer (default build)
module tb_meta_buffer;

  logic clk;
  logic rst_n;

  meta_buffer_if #(
    .meta_glb_t  (logic [7:0]),
    .meta_seglv_t(logic [3:0]),
    .Depth       (4)
  ) mif ();

  meta_buffer #(
    .Depth       (4),
    .meta_glb_t  (logic [7:0]),
    .meta_seglv_t(logic [3:0])
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .enq_valid_i(mif.enq_valid),
    .enq_ready_o(mif.enq_ready),
    .enq_glb_i  (mif.enq_glb),
    .enq_seglv_i(mif.enq_seglv),
    .deq_valid_o(mif.deq_valid),
    .deq_ready_i(mif.deq_ready),
    .deq_glb_o  (mif.deq_glb),
    .deq_seglv_o(mif.deq_seglv),
    .usage_o    (mif.usage),
    .empty_o    (mif.empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] sb[$];

  typedef struct {
    logic       ev;
    logic [7:0] g;
    logic [3:0] s;
    logic       dr;
    int         usage;
    logic       rdy;
    logic       vld;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle, check status and head against the queue model at the
  // falling edge, then update the model with what the handshake accepted.
  task automatic step(input logic ev, input logic [7:0] g, input logic [3:0] s,
                      input logic dr, input bit has_exp, input int exp_usage,
                      input logic exp_rdy, input logic exp_vld);
    int  cnt;
    bit  p;
    bit  q;
    mif.enq_valid = ev;
    mif.enq_glb   = g;
    mif.enq_seglv = s;
    mif.deq_ready = dr;
    @(negedge clk);
    cnt = sb.size();
    chk("usage", 32'(mif.usage), cnt);
    chk("enq_ready", 32'(mif.enq_ready), 32'(cnt != 4));
    chk("deq_valid", 32'(mif.deq_valid), 32'(cnt != 0));
    chk("empty", 32'(mif.empty), 32'(cnt == 0));
    if (cnt != 0) chk("head", 32'({mif.deq_glb, mif.deq_seglv}), 32'(sb[0]));
    if (has_exp) begin
      chk("vec_usage", 32'(mif.usage), exp_usage);
      chk("vec_ready", 32'(mif.enq_ready), 32'(exp_rdy));
      chk("vec_valid", 32'(mif.deq_valid), 32'(exp_vld));
    end
    p = ev && (cnt != 4);
    q = dr && (cnt != 0);
    if (q) void'(sb.pop_front());
    if (p) sb.push_back({g, s});
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && sb.size() != 0; k++) step(1'b0, 8'h0, 4'h0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 8'hA1, 4'h1, 1'b0, 0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 8'hB2, 4'h2, 1'b0, 1, 1'b1, 1'b1};
    vecs[2]  = '{1'b1, 8'hC3, 4'h3, 1'b0, 2, 1'b1, 1'b1};
    vecs[3]  = '{1'b1, 8'hD4, 4'h4, 1'b0, 3, 1'b1, 1'b1};
    vecs[4]  = '{1'b1, 8'hE5, 4'h5, 1'b0, 4, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 8'hE5, 4'h5, 1'b1, 4, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 8'h00, 4'h0, 1'b0, 3, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 8'h00, 4'h0, 1'b1, 3, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 8'h00, 4'h0, 1'b1, 2, 1'b1, 1'b1};
    vecs[9]  = '{1'b0, 8'h00, 4'h0, 1'b1, 1, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 8'h6A, 4'h6, 1'b1, 0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 8'h00, 4'h0, 1'b0, 1, 1'b1, 1'b1};
    vecs[12] = '{1'b0, 8'h00, 4'h0, 1'b1, 1, 1'b1, 1'b1};
    vecs[13] = '{1'b0, 8'h00, 4'h0, 1'b0, 0, 1'b1, 1'b0};

    rst_n         = 1'b0;
    mif.enq_valid = 1'b0;
    mif.enq_glb   = 8'h0;
    mif.enq_seglv = 4'h0;
    mif.deq_ready = 1'b0;
    #12;
    chk("rst_usage", 32'(mif.usage), 0);
    chk("rst_ready", 32'(mif.enq_ready), 1);
    chk("rst_valid", 32'(mif.deq_valid), 0);
    chk("rst_empty", 32'(mif.empty), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill, full refusal, pop on full, drain, single-cycle latency.
    for (int i = 0; i < 14; i++)
      step(vecs[i].ev, vecs[i].g, vecs[i].s, vecs[i].dr, 1'b1,
           vecs[i].usage, vecs[i].rdy, vecs[i].vld);

    // Steady state at usage 2 with push and pop every cycle; pointers wrap.
    step(1'b1, 8'h10, 4'h0, 1'b0, 1'b1, 0, 1'b1, 1'b0);
    step(1'b1, 8'h11, 4'h1, 1'b0, 1'b1, 1, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++)
      step(1'b1, 8'(8'h20 + i), 4'(i), 1'b1, 1'b1, 2, 1'b1, 1'b1);
    drain();

    // Asynchronous reset with three entries stored.
    step(1'b1, 8'h31, 4'h1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    step(1'b1, 8'h32, 4'h2, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    step(1'b1, 8'h33, 4'h3, 1'b0, 1'b1, 2, 1'b1, 1'b1);
    mif.enq_valid = 1'b1;
    mif.enq_glb   = 8'hEE;
    mif.enq_seglv = 4'hE;
    mif.deq_ready = 1'b1;
    @(negedge clk);
    chk("pre_rst_usage", 32'(mif.usage), 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_usage", 32'(mif.usage), 0);
    chk("arst_valid", 32'(mif.deq_valid), 0);
    chk("arst_ready", 32'(mif.enq_ready), 1);
    chk("arst_empty", 32'(mif.empty), 1);
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    mif.enq_valid = 1'b0;
    mif.deq_ready = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 8'h5A, 4'h5, 1'b0, 1'b1, 0, 1'b1, 1'b0);
    step(1'b1, 8'h5B, 4'h6, 1'b0, 1'b1, 1, 1'b1, 1'b1);
    drain();

    // Random traffic against the queue model.
    for (int i = 0; i < 10000; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 4'($urandom),
           1'($urandom_range(0, 1)), 1'b0, 0, 1'b0, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
